// File: rtl/fwd_hazard_unit_pkg.sv
// Shared encodings for the forwarding/hazard unit: operand select codes, MDU state enum
// and the MDU countdown width helper.
package fwd_hazard_unit_pkg;

   localparam logic [1:0] FWD_REG = 2'd0;
   localparam logic [1:0] FWD_W   = 2'd1;
   localparam logic [1:0] FWD_M   = 2'd2;

   typedef enum logic [1:0] {
      MDU_IDLE = 2'd0,
      MDU_BUSY = 2'd1,
      MDU_DONE = 2'd2
   } mduState_e;

   // Countdown runs MDU_LAT-1..0, so a one- or two-cycle MDU still needs one bit.
   function automatic int cntWidth(input int lat);
      return (lat <= 2) ? 1 : $clog2(lat);
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Datapath-side bundle of the forwarding/hazard unit; master drives pipeline state,
// slave is the unit itself.
interface fwd_hazard_unit_if #(
   parameter int DW   = 32,
   parameter int AW   = 5,
   parameter int NSRC = 2,
   parameter int CNTW = 16
);
   logic [NSRC*AW-1:0] rs_d;
   logic [NSRC*AW-1:0] rs_e;
   logic [NSRC*DW-1:0] rd_e;
   logic [AW-1:0]      writereg_e;
   logic               regwrite_e;
   logic               memtoreg_e;
   logic [AW-1:0]      writereg_m;
   logic               regwrite_m;
   logic [DW-1:0]      aluout_m;
   logic [AW-1:0]      writereg_w;
   logic               regwrite_w;
   logic [DW-1:0]      result_w;
   logic               mdu_start_e;
   logic               mdu_use_d;

   logic [NSRC*DW-1:0] src_e;
   logic [NSRC*2-1:0]  fwd_sel;
   logic               stall_f;
   logic               stall_d;
   logic               flush_e;
   logic               mdu_busy;
   logic               mdu_done;
   logic [CNTW-1:0]    stall_cnt;

   modport master (
      output rs_d, rs_e, rd_e, writereg_e, regwrite_e, memtoreg_e,
             writereg_m, regwrite_m, aluout_m, writereg_w, regwrite_w, result_w,
             mdu_start_e, mdu_use_d,
      input  src_e, fwd_sel, stall_f, stall_d, flush_e, mdu_busy, mdu_done, stall_cnt
   );

   modport slave (
      input  rs_d, rs_e, rd_e, writereg_e, regwrite_e, memtoreg_e,
             writereg_m, regwrite_m, aluout_m, writereg_w, regwrite_w, result_w,
             mdu_start_e, mdu_use_d,
      output src_e, fwd_sel, stall_f, stall_d, flush_e, mdu_busy, mdu_done, stall_cnt
   );

endinterface

// File: rtl/fwd_hazard_unit_fwd_sel_mux.sv
// One E-stage operand: picks regfile, W or M value by destination match (M wins).
// Purely combinational, no backpressure.
module fwd_sel_mux
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DW = 32,
   parameter int AW = 5
) (
   input  logic [AW-1:0] rsE,
   input  logic [DW-1:0] rdE,
   input  logic          regwriteM,
   input  logic [AW-1:0] writeregM,
   input  logic [DW-1:0] aluoutM,
   input  logic          regwriteW,
   input  logic [AW-1:0] writeregW,
   input  logic [DW-1:0] resultW,
   output logic [1:0]    sel,
   output logic [DW-1:0] src
);

   logic hitM;
   logic hitW;

   // r0 is hardwired zero, so a write to it must never be forwarded.
   assign hitM = regwriteM && (writeregM != '0) && (writeregM == rsE);
   assign hitW = regwriteW && (writeregW != '0) && (writeregW == rsE);

   always_comb begin
      sel = FWD_REG;
      src = rdE;
      if (hitM) begin
         sel = FWD_M;
         src = aluoutM;
      end else if (hitW) begin
         sel = FWD_W;
         src = resultW;
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use / MDU hazard stalls and a saturating stall counter.
// Forwarding and stall outputs are same-cycle combinational; MDU status is registered.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int DW      = 32,
   parameter int AW      = 5,
   parameter int NSRC    = 2,
   parameter int MDU_LAT = 4,
   parameter int CNTW    = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   fwd_hazard_unit_if.slave  hif
);

   localparam int MCW = cntWidth(MDU_LAT);

   logic [NSRC*DW-1:0] srcE;
   logic [NSRC*2-1:0]  fwdSel;

   for (genvar i = 0; i < NSRC; i++) begin : gOperand
      fwd_sel_mux #(.DW(DW), .AW(AW)) uMux (
         .rsE       (hif.rs_e[i*AW +: AW]),
         .rdE       (hif.rd_e[i*DW +: DW]),
         .regwriteM (hif.regwrite_m),
         .writeregM (hif.writereg_m),
         .aluoutM   (hif.aluout_m),
         .regwriteW (hif.regwrite_w),
         .writeregW (hif.writereg_w),
         .resultW   (hif.result_w),
         .sel       (fwdSel[i*2 +: 2]),
         .src       (srcE[i*DW +: DW])
      );
   end

   assign hif.src_e   = srcE;
   assign hif.fwd_sel = fwdSel;

   logic lwHit;
   logic lwStall;
   logic mduStall;
   logic stall;

   always_comb begin
      lwHit = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
         if (hif.rs_d[i*AW +: AW] == hif.writereg_e) lwHit = 1'b1;
      end
   end

   mduState_e       mduState;
   logic [MCW-1:0]  mduCnt;
   logic            busyQ;
   logic            doneQ;

   assign lwStall  = hif.regwrite_e && hif.memtoreg_e && (hif.writereg_e != '0) && lwHit;
   // A start in this cycle already blocks a dependent D-stage reader.
   assign mduStall = hif.mdu_use_d && (busyQ || hif.mdu_start_e);
   assign stall    = lwStall || mduStall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mduState <= MDU_IDLE;
         mduCnt   <= '0;
         busyQ    <= 1'b0;
         doneQ    <= 1'b0;
      end else begin
         case (mduState)
            MDU_BUSY: begin
               if (mduCnt == '0) begin
                  mduState <= MDU_DONE;
                  busyQ    <= 1'b0;
                  doneQ    <= 1'b1;
               end else begin
                  mduCnt   <= mduCnt - 1'b1;
               end
            end
            default: begin
               doneQ <= 1'b0;
               if (hif.mdu_start_e) begin
                  mduState <= MDU_BUSY;
                  mduCnt   <= MCW'(MDU_LAT - 1);
                  busyQ    <= 1'b1;
               end else begin
                  mduState <= MDU_IDLE;
                  busyQ    <= 1'b0;
               end
            end
         endcase
      end
   end

   logic [CNTW-1:0] stallCnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stallCnt <= '0;
      end else if (stall && (stallCnt != '1)) begin
         stallCnt <= stallCnt + 1'b1;
      end
   end

   assign hif.stall_f   = stall;
   assign hif.stall_d   = stall;
   assign hif.flush_e   = stall;
   assign hif.mdu_busy  = busyQ;
   assign hif.mdu_done  = doneQ;
   assign hif.stall_cnt = stallCnt;

endmodule
